// File: rtl/key_sched_pkg.sv
// Shared types and the round-robin selection helper for the key-start scheduler.
package key_sched_pkg;

    localparam int MAX_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} sched_state_t;

    // First set bit of pend searching upward from ptr+1, wrapping modulo n.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_N-1:0] pend,
                                                 input logic [IDX_W-1:0] ptr,
                                                 input int n);
        logic [IDX_W-1:0] sel;
        int idx;
        sel = ptr;
        for (int i = MAX_N; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(ptr) + i) % n;
                if (pend[idx]) sel = IDX_W'(idx);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module sync_2ff #(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] meta_reg;
    logic [BITS-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/key_start_sched.sv
// Debounces N request keys, queues presses and round-robin sequences a shared
// datapath through a start/done pulse handshake with a one-hot grant.
module key_start_sched
    import key_sched_pkg::*;
#(
    parameter  int N          = 2,
    parameter  int DEB_CYCLES = 4,
    localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_key,
    input  logic         dp_done,
    output logic         dp_start,
    output logic [N-1:0] grant,
    output logic [N-1:0] pending,
    output logic         idle
);

    logic [N-1:0] sync;
    logic [N-1:0] stable;
    logic [N-1:0] stable_d_reg;
    logic [N-1:0] pending_reg;
    logic [N-1:0] rise;
    logic [N-1:0] clr;

    sync_2ff #(.BITS(N)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_key),
        .q     (sync)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;

            // The level flips only on the DEB_CYCLES-th consecutive disagreeing cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                    stable_reg <= sync[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    assign rise = stable & ~stable_d_reg;

    // A press landing on the clearing cycle survives, so it queues a fresh job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d_reg <= '0;
            pending_reg  <= '0;
        end else begin
            stable_d_reg <= stable;
            pending_reg  <= (pending_reg & ~clr) | rise;
        end
    end

    sched_state_t     state_reg, state_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] pick;
    logic [MAX_N-1:0] pend_wide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            ptr_reg   <= IDX_W'(N - 1);
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        pend_wide          = '0;
        pend_wide[N-1:0]   = pending_reg;
        pick               = rr_pick(pend_wide, ptr_reg, N);
        state_next         = state_reg;
        grant_next         = grant_reg;
        ptr_next           = ptr_reg;
        owner_next         = owner_reg;
        clr                = '0;
        case (state_reg)
            S_IDLE: begin
                if (|pending_reg) begin
                    owner_next = pick;
                    grant_next = N'(1) << pick;
                    clr        = N'(1) << pick;
                    state_next = S_START;
                end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (dp_done) begin
                    grant_next = '0;
                    ptr_next   = owner_reg;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dp_start = (state_reg == S_START);
    assign idle     = (state_reg == S_IDLE);
    assign grant    = grant_reg;
    assign pending  = pending_reg;

endmodule

// File: tb/tb_key_start_sched.sv
// Directed scenarios plus randomized key/done traffic checked against a
// window-based behavioural model of the scheduler.
module tb_key_start_sched;

    localparam int N   = 2;
    localparam int DEB = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] raw_key;
    logic         dp_done;
    logic         dp_start;
    logic [N-1:0] grant;
    logic [N-1:0] pending;
    logic         idle;

    int errors = 0;
    int checks = 0;

    key_start_sched #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_key  (raw_key),
        .dp_done  (dp_done),
        .dp_start (dp_start),
        .grant    (grant),
        .pending  (pending),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: key level = majority-free "last DEB samples all differ" rule.
    logic [N-1:0]   m_ff1, m_sync, m_stable, m_stable_d, m_pend;
    logic [DEB-1:0] m_win [N];
    int             m_phase;   // 0 idle, 1 start cycle, 2 waiting for done
    int             m_owner;
    int             m_ptr;

    task automatic model_clear();
        m_ff1 = '0; m_sync = '0; m_stable = '0; m_stable_d = '0; m_pend = '0;
        for (int i = 0; i < N; i++) m_win[i] = '0;
        m_phase = 0; m_owner = -1; m_ptr = N - 1;
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] e;
        e = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        return e;
    endfunction

    // Advance one clock: model sees the same pre-edge inputs as the DUT.
    task automatic step();
        logic [N-1:0] rise, clr;
        int sel;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            rise = m_stable & ~m_stable_d;
            clr  = '0;
            if (m_phase == 0) begin
                if (m_pend != 0) begin
                    sel = -1;
                    for (int j = 1; j <= N; j++)
                        if (sel < 0 && m_pend[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
                    clr[sel] = 1'b1;
                    m_owner  = sel;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (dp_done) begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_phase = 0;
            end
            m_pend     = (m_pend & ~clr) | rise;
            m_stable_d = m_stable;
            for (int i = 0; i < N; i++) begin
                m_win[i] = (m_win[i] << 1) | DEB'(m_sync[i]);
                if (m_win[i] == {DEB{~m_stable[i]}}) m_stable[i] = ~m_stable[i];
            end
            m_sync = m_ff1;
            m_ff1  = raw_key;
        end
        @(negedge clk);
    endtask

    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int c = 0; c < limit && !found; c++) begin
            step();
            if (dp_start === 1'b1) found = 1'b1;
        end
        if (found) $display("start: grant=%b pending=%b t=%0t", grant, pending, $time);
    endtask

    task automatic finish_job();
        step();
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
    endtask

    task automatic settle(input int n);
        raw_key = '0;
        dp_done = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        bit found;
        raw_key = 2'b11;
        dp_done = 1'b0;
        reset   = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            step();
            checks += 4;
            if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
            if (dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start: got %b expected 0", dp_start); end
            if (pending !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b expected 00", pending); end
            if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        end
        reset = 1'b1;
        wait_start(20, found);
        checks += 2;
        if (!found) begin errors++; $display("FAIL reset_first_start: got timeout expected dp_start"); end
        if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", grant); end
    endtask

    task automatic test_contention();
        bit found;
        checks++;
        if (pending !== 2'b10) begin errors++; $display("FAIL cont_pending: got %b expected 10", pending); end
        repeat (3) step();
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        checks += 3;
        if (grant !== 2'b00) begin errors++; $display("FAIL cont_gap_grant: got %b expected 00", grant); end
        if (idle !== 1'b1) begin errors++; $display("FAIL cont_gap_idle: got %b expected 1", idle); end
        if (dp_start !== 1'b0) begin errors++; $display("FAIL cont_gap_start: got %b expected 0", dp_start); end
        step();
        $display("start: grant=%b pending=%b t=%0t", grant, pending, $time);
        checks += 2;
        if (grant !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b expected 10", grant); end
        if (dp_start !== 1'b1) begin errors++; $display("FAIL cont_second_start: got %b expected 1", dp_start); end
        finish_job();
        settle(12);
        // Pointer now rests on key1, so key0 wins a fresh tie.
        raw_key = 2'b11;
        wait_start(20, found);
        checks += 2;
        if (!found) begin errors++; $display("FAIL cont_rr_start: got timeout expected dp_start"); end
        if (grant !== 2'b01) begin errors++; $display("FAIL cont_rr_grant: got %b expected 01", grant); end
        finish_job();
        wait_start(10, found);
        checks++;
        if (grant !== 2'b10) begin errors++; $display("FAIL cont_rr_next: got %b expected 10", grant); end
        finish_job();
        settle(12);
    endtask

    task automatic test_single_press();
        raw_key = 2'b01;
        repeat (7) step();
        checks += 3;
        if (pending !== 2'b01) begin errors++; $display("FAIL single_pending: got %b expected 01", pending); end
        if (grant !== 2'b00) begin errors++; $display("FAIL single_early_grant: got %b expected 00", grant); end
        if (dp_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b expected 0", dp_start); end
        step();
        $display("start: grant=%b pending=%b t=%0t", grant, pending, $time);
        checks += 3;
        if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
        if (dp_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", dp_start); end
        if (pending !== 2'b00) begin errors++; $display("FAIL single_cleared: got %b expected 00", pending); end
        repeat (5) step();
        checks += 3;
        if (dp_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", dp_start); end
        if (grant !== 2'b01) begin errors++; $display("FAIL single_hold: got %b expected 01", grant); end
        if (idle !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", idle); end
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        checks += 2;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", grant); end
        if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", idle); end
        settle(12);
    endtask

    task automatic test_glitch();
        bit found;
        raw_key = 2'b01;
        repeat (3) step();
        raw_key = 2'b00;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (pending !== 2'b00 || grant !== 2'b00 || dp_start !== 1'b0)
                begin errors++; $display("FAIL glitch_reject: got p=%b g=%b s=%b expected all 0", pending, grant, dp_start); end
        end
        // A pulse of exactly DEB cycles is the shortest that must register.
        raw_key = 2'b10;
        repeat (4) step();
        raw_key = 2'b00;
        wait_start(10, found);
        checks += 2;
        if (!found) begin errors++; $display("FAIL glitch_min_start: got timeout expected dp_start"); end
        if (grant !== 2'b10) begin errors++; $display("FAIL glitch_min_grant: got %b expected 10", grant); end
        finish_job();
        settle(12);
    endtask

    task automatic test_repress();
        bit found;
        raw_key = 2'b01;
        wait_start(20, found);
        checks++;
        if (!found || grant !== 2'b01) begin errors++; $display("FAIL repress_first: got %b expected 01", grant); end
        repeat (3) step();
        raw_key = 2'b00;
        repeat (8) step();
        raw_key = 2'b01;
        repeat (9) step();
        checks += 2;
        if (pending !== 2'b01) begin errors++; $display("FAIL repress_pending: got %b expected 01", pending); end
        if (grant !== 2'b01) begin errors++; $display("FAIL repress_owner: got %b expected 01", grant); end
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL repress_gap: got %b expected 00", grant); end
        step();
        $display("start: grant=%b pending=%b t=%0t", grant, pending, $time);
        checks += 2;
        if (grant !== 2'b01) begin errors++; $display("FAIL repress_regrant: got %b expected 01", grant); end
        if (dp_start !== 1'b1) begin errors++; $display("FAIL repress_start: got %b expected 1", dp_start); end
        finish_job();
        settle(12);
    endtask

    task automatic test_mid_reset();
        bit found;
        raw_key = 2'b10;
        wait_start(20, found);
        step();
        step();
        checks++;
        if (grant !== 2'b10 || idle !== 1'b0) begin errors++; $display("FAIL midrst_busy: got g=%b i=%b expected 10/0", grant, idle); end
        raw_key = 2'b00;
        reset   = 1'b0;
        #1;
        model_clear();
        checks += 3;
        if (grant !== 2'b00) begin errors++; $display("FAIL midrst_grant_async: got %b expected 00", grant); end
        if (dp_start !== 1'b0) begin errors++; $display("FAIL midrst_start_async: got %b expected 0", dp_start); end
        if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle_async: got %b expected 1", idle); end
        step();
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            checks++;
            if (grant !== 2'b00 || pending !== 2'b00) begin errors++; $display("FAIL midrst_quiet: got g=%b p=%b expected 00/00", grant, pending); end
        end
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 10);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    raw_key[i] = ~raw_key[i];
                    hold[i] = $urandom_range(1, 10);
                end
            end
            dp_done = ($urandom_range(0, 5) == 0);
            step();
            if (dp_start === 1'b1) $display("rand start: grant=%b pending=%b t=%0t", grant, pending, $time);
            checks += 4;
            if (grant !== exp_grant()) begin errors++; $display("FAIL rand_grant: got %b expected %b t=%0t", grant, exp_grant(), $time); end
            if (pending !== m_pend) begin errors++; $display("FAIL rand_pending: got %b expected %b t=%0t", pending, m_pend, $time); end
            if (dp_start !== (m_phase == 1)) begin errors++; $display("FAIL rand_start: got %b expected %b t=%0t", dp_start, (m_phase == 1), $time); end
            if (idle !== (m_phase == 0)) begin errors++; $display("FAIL rand_idle: got %b expected %b t=%0t", idle, (m_phase == 0), $time); end
        end
        dp_done = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        raw_key = '0;
        dp_done = 1'b0;
        model_clear();
        #1;
        test_reset();
        test_contention();
        test_single_press();
        test_glitch();
        test_repress();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
